// File: rtl/pwm_capture_wb.sv
// pwm_capture_wb: Wishbone slave that measures the high time and period of one
// external PWM input in clk_i cycles, with a coherent HIGH/PERIOD pair and IRQ.
//
// state     | meaning
// IDLE      | capture disabled, counter held at 0
// WAIT_RISE | armed, waiting for a rising edge to start a period
// HIGH_PH   | counting the high phase
// LOW_PH    | counting the low phase; next rising edge completes the period
module pwm_capture_wb #(
  parameter int CW          = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic [3:0]  sel_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  output logic        ack_o,
  output logic        IRQ,
  input  logic        pwm_in
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_RISE, S_HIGH_PH, S_LOW_PH} state_t;

  state_t                 state_q;
  logic                   ack_q;
  logic [31:0]            dat_q;
  logic                   en_q, pol_q;
  logic [3:0]             filt_q;
  logic [1:0]             im_q;
  logic                   valid_q, ovf_q, irq_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [3:0]             fcnt_q;
  logic                   level_q, level_prev_q;
  logic [CW-1:0]          cnt_q, high_lat_q, high_q, period_q;

  logic        req, wr, ctrl_wr, stat_wr, im_wr;
  logic [2:0]  word;
  logic        en_d, pol_d;
  logic [3:0]  filt_d;
  logic [1:0]  clr;
  logic [31:0] rdata;
  logic        sample, rise, fall, measuring, sat, valid_set, ovf_set;
  logic        unused_ok;

  assign unused_ok = ^{adr_i[31:5], adr_i[1:0], dat_i[31:8], dat_i[3:2], sel_i[3:1]};

  // Bus decode and next value of the CTRL fields.
  always_comb begin
    req     = cyc_i & stb_i & ~ack_q;
    wr      = req & we_i;
    word    = adr_i[4:2];
    ctrl_wr = wr && (word == 3'd0);
    stat_wr = wr && (word == 3'd1) && sel_i[0];
    im_wr   = wr && (word == 3'd4) && sel_i[0];
    en_d    = en_q;
    pol_d   = pol_q;
    filt_d  = filt_q;
    if (ctrl_wr && sel_i[0]) begin
      en_d   = dat_i[0];
      pol_d  = dat_i[1];
      filt_d = dat_i[7:4];
    end
    clr = stat_wr ? dat_i[1:0] : 2'b00;
  end

  // Read-data mux; unmapped words return 0.
  always_comb begin
    rdata = '0;
    case (word)
      3'd0:    rdata = {24'd0, filt_q, 2'b00, pol_q, en_q};
      3'd1:    rdata = {29'd0, level_q, ovf_q, valid_q};
      3'd2:    rdata = 32'(high_q);
      3'd3:    rdata = 32'(period_q);
      3'd4:    rdata = {30'd0, im_q};
      default: rdata = '0;
    endcase
  end

  // Single-cycle ack, registered read data, CTRL and IM registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      en_q   <= 1'b0;
      pol_q  <= 1'b0;
      filt_q <= '0;
      im_q   <= '0;
    end else begin
      ack_q  <= req;
      dat_q  <= req ? rdata : '0;
      en_q   <= en_d;
      pol_q  <= pol_d;
      filt_q <= filt_d;
      if (im_wr) im_q <= dat_i[1:0];
    end
  end

  assign sample = sync_q[SYNC_STAGES-1] ^ pol_q;

  // Synchroniser and glitch filter: level follows after FILT+1 equal samples.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q       <= '0;
      fcnt_q       <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      level_prev_q <= level_q;
      if (sample == level_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q >= filt_q) begin
        level_q <= sample;
        fcnt_q  <= '0;
      end else begin
        fcnt_q <= fcnt_q + 4'd1;
      end
    end
  end

  // Edge detect and status set conditions; a CTRL write pre-empts everything.
  always_comb begin
    rise      = level_q & ~level_prev_q;
    fall      = ~level_q & level_prev_q;
    measuring = (state_q == S_HIGH_PH) || (state_q == S_LOW_PH);
    sat       = measuring && (cnt_q == CNT_MAX);
    ovf_set   = !ctrl_wr && en_q && sat;
    valid_set = !ctrl_wr && en_q && !sat && (state_q == S_LOW_PH) && rise;
  end

  // Capture FSM, measurement counter, result registers and STATUS.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      high_lat_q <= '0;
      high_q     <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      valid_q <= (valid_q & ~clr[0]) | valid_set;
      ovf_q   <= (ovf_q & ~clr[1]) | ovf_set;
      if (ctrl_wr) begin
        state_q <= en_d ? S_WAIT_RISE : S_IDLE;
        cnt_q   <= '0;
      end else if (!en_q) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else if (sat) begin
        state_q <= S_WAIT_RISE;
      end else begin
        if (rise) cnt_q <= CNT_ONE;
        else if (measuring) cnt_q <= cnt_q + CNT_ONE;
        case (state_q)
          S_IDLE:      state_q <= S_WAIT_RISE;
          S_WAIT_RISE: if (rise) state_q <= S_HIGH_PH;
          S_HIGH_PH: begin
            if (fall) begin
              high_lat_q <= cnt_q;
              state_q    <= S_LOW_PH;
            end
          end
          S_LOW_PH: begin
            if (rise) begin
              period_q <= cnt_q;
              high_q   <= high_lat_q;
              state_q  <= S_HIGH_PH;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Registered level interrupt.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) irq_q <= 1'b0;
    else         irq_q <= |({ovf_q, valid_q} & im_q);
  end

  assign ack_o = ack_q;
  assign dat_o = dat_q;
  assign IRQ   = irq_q;

endmodule

// File: doc/pwm_capture_wb.md
Name: pwm_capture_wb

Overview:
Wishbone-slave PWM input-capture peripheral, the receive-side counterpart of the PWM timer peripherals on the user-project Wishbone bus. It synchronises and glitch-filters one external PWM input, then measures high time and period in clk_i cycles. It exposes the results in a coherent register pair and raises a maskable IRQ. It occupies one 4 KB slot behind the bus splitter; its input comes from a GPIO.

Parameters:
CW, 32, measurement counter width (8..32); values are zero-extended to 32 bits on read.
SYNC_STAGES, 2, input synchroniser depth (>=2).

Ports:
clk_i  input  1  Wishbone and capture clock.
rst_ni  input  1  Asynchronous reset, active-low.
adr_i  input  32  Wishbone address; only [4:2] are decoded.
dat_i  input  32  Write data.
dat_o  output  32  Read data.
sel_i  input  4  Byte selects; writes honour them per byte.
cyc_i  input  1  Bus cycle.
stb_i  input  1  Strobe.
we_i  input  1  Write enable.
ack_o  output  1  Transfer acknowledge.
IRQ  output  1  Level interrupt.
pwm_in  input  1  Asynchronous PWM input.

Behaviour:
- Reset is asynchronous and active-low. All registers, FSM, synchroniser and filter clear to 0. At reset ack_o=0, dat_o=0, IRQ=0. FSM resets to IDLE.
- Bus: ack_o pulses for 1 cycle, one cycle after cyc_i&stb_i&!ack_o. dat_o is registered and valid with ack_o. There is no back-to-back ack: the next ack is at the earliest 2 cycles later. Unmapped words read 0 and ignore writes.
- Register map:
  - 0x00 CTRL (RW): [0] EN, [1] POL (invert input), [7:4] FILT.
  - 0x04 STATUS: [0] VALID (W1C), [1] OVF (W1C), [2] LEVEL (RO, filtered level).
  - 0x08 HIGH (RO).
  - 0x0C PERIOD (RO).
  - 0x10 IM (RW) [1:0].
- Input path: pwm_in feeds SYNC_STAGES flops, then XOR with POL, then the filter. The filtered level changes only after FILT+1 consecutive equal synchronised samples; FILT=0 means pass-through via one register. Edge detect compares the filtered level with its previous value. Latency from pin to edge is fixed, so measurements are unbiased.
- Counter cnt (CW bits) behaviour:
  - A rising edge loads 1.
  - Otherwise, while measuring, it increments and saturates at 2^CW-1.
- FSM states:
  - IDLE: EN=0; cnt=0. Goes to WAIT_RISE when EN=1.
  - WAIT_RISE: on rising edge goes to HIGH_PH.
  - HIGH_PH: on falling edge, high_lat<=cnt, then goes to LOW_PH.
  - LOW_PH: on rising edge, PERIOD<=cnt, HIGH<=high_lat (same cycle, coherent), VALID<=1, then goes to HIGH_PH.
- Saturation: if cnt reaches 2^CW-1 in HIGH_PH or LOW_PH, OVF<=1 and the FSM goes to WAIT_RISE. HIGH and PERIOD are not updated. A stuck input therefore produces OVF.
- EN=0 forces IDLE next cycle from any state. HIGH, PERIOD and STATUS are retained.
- Any CTRL write while the resulting EN=1 restarts the FSM at WAIT_RISE, discarding any partial measurement.
- Simultaneous hardware set and W1C clear of the same STATUS bit: set wins.
- IRQ is registered: IRQ <= |(STATUS[1:0] & IM). It follows STATUS one cycle later.
- 100 % or 0 % duty is not measurable; it reports OVF.

Test Plan:
- Reset check: assert rst_ni=0 mid-measurement -> ack_o, IRQ, dat_o, HIGH, PERIOD and STATUS read 0 after release; FSM is in IDLE.
- Basic capture: EN=1, FILT=0, POL=0; pwm_in high 3, low 5, repeating -> HIGH=3, PERIOD=8, VALID=1; IM=1 -> IRQ=1. Write STATUS=1 -> VALID=0 and IRQ=0 one cycle later.
- POL=1 with the same stimulus -> HIGH=5, PERIOD=8.
- Glitch filter: FILT=3; 2-cycle low glitches inside a 20-high/30-low waveform -> HIGH=20, PERIOD=50, with no extra VALID events. With FILT=0 the same glitches corrupt HIGH.
- Overflow: CW=8, pwm_in held high after a rising edge -> OVF=1 after 254 cycles; IM=2 -> IRQ=1; HIGH and PERIOD are unchanged; FSM is in WAIT_RISE.
- Boundaries:
  - Clear VALID on the exact cycle a new capture completes -> VALID stays 1.
  - Write CTRL mid-period -> no capture until two further rising edges.
  - EN=0 mid-measurement -> IDLE, and prior HIGH/PERIOD are retained.
  - Read 0x14 -> 0.
